alu_issue_ctrl: RTL

- Driving end of the datapath ALU interface. Decodes RV32I instruction fields into the 4-bit ALU control code and selects SrcA/SrcB.
- Presents the selected operands to the combinational ALU from a registered issue stage.
- Captures ALUResult/Zero in a writeback stage and resolves branch-taken from Zero.
- Two-stage valid/ready pipeline between the decode front end and register writeback/PC logic.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/alu_ctl_decode.sv | 79 +++++++
 rtl/alu_issue_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, RV32I opcodes and operand-select encodings.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_BNE  = 4'd10;
    localparam logic [3:0] ALU_BLT  = 4'd11;
    localparam logic [3:0] ALU_BGE  = 4'd12;
    localparam logic [3:0] ALU_BLTU = 4'd13;
    localparam logic [3:0] ALU_BGEU = 4'd14;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        A_ZERO = 2'd0,
        A_RS1  = 2'd1,
        A_PC   = 2'd2
    } a_sel_t;

    typedef enum logic [1:0] {
        B_ZERO = 2'd0,
        B_RS2  = 2'd1,
        B_IMM  = 2'd2,
        B_FOUR = 2'd3
    } b_sel_t;

    // Register/immediate arithmetic mapping; funct7_5 only selects SUB when
    // sub_ok is set (register form), but always selects SRA for funct3=101.
    function automatic logic [3:0] arith_ctl(input logic [2:0] funct3,
                                             input logic       funct7_5,
                                             input logic       sub_ok);
        logic [3:0] ctl;
        case (funct3)
            3'b000:  ctl = (sub_ok && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  ctl = ALU_SLL;
            3'b010:  ctl = ALU_SLT;
            3'b011:  ctl = ALU_SLTU;
            3'b100:  ctl = ALU_XOR;
            3'b101:  ctl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  ctl = ALU_OR;
            default: ctl = ALU_AND;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of RV32I fields into ALU control and operand selects.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctl,
    output a_sel_t     a_sel,
    output b_sel_t     b_sel,
    output logic       shift_mask,
    output logic       is_branch,
    output logic       is_jump,
    output logic       illegal
);

    // Illegal encodings fall through to ADD with both operands forced to zero.
    always_comb begin
        alu_ctl    = ALU_ADD;
        a_sel      = A_ZERO;
        b_sel      = B_ZERO;
        shift_mask = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                a_sel      = A_RS1;
                b_sel      = B_RS2;
                alu_ctl    = arith_ctl(funct3, funct7_5, 1'b1);
                shift_mask = (funct3 == 3'b001) || (funct3 == 3'b101);
            end
            OPC_OP_IMM: begin
                a_sel      = A_RS1;
                b_sel      = B_IMM;
                alu_ctl    = arith_ctl(funct3, funct7_5, 1'b0);
                shift_mask = (funct3 == 3'b001) || (funct3 == 3'b101);
            end
            OPC_BRANCH: begin
                a_sel     = A_RS1;
                b_sel     = B_RS2;
                is_branch = 1'b1;
                case (funct3)
                    3'b000:  alu_ctl = ALU_SUB;
                    3'b001:  alu_ctl = ALU_BNE;
                    3'b100:  alu_ctl = ALU_BLT;
                    3'b101:  alu_ctl = ALU_BGE;
                    3'b110:  alu_ctl = ALU_BLTU;
                    3'b111:  alu_ctl = ALU_BGEU;
                    default: begin
                        illegal   = 1'b1;
                        is_branch = 1'b0;
                        a_sel     = A_ZERO;
                        b_sel     = B_ZERO;
                    end
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                a_sel = A_RS1;
                b_sel = B_IMM;
            end
            OPC_LUI: begin
                a_sel = A_ZERO;
                b_sel = B_IMM;
            end
            OPC_AUIPC: begin
                a_sel = A_PC;
                b_sel = B_IMM;
            end
            OPC_JAL, OPC_JALR: begin
                a_sel   = A_PC;
                b_sel   = B_FOUR;
                is_jump = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/writeback pipeline driving an external combinational ALU.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7_5,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_pc,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    output logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_branch_taken,
    output logic             out_illegal
);

    logic [3:0]       dec_ctl;
    a_sel_t           dec_a_sel;
    b_sel_t           dec_b_sel;
    logic             dec_shift_mask;
    logic             dec_is_branch;
    logic             dec_is_jump;
    logic             dec_illegal;
    logic [WIDTH-1:0] src_a_next;
    logic [WIDTH-1:0] src_b_raw;
    logic [WIDTH-1:0] src_b_next;

    logic             s1_valid;
    logic             s1_is_branch;
    logic             s1_is_jump;
    logic             s1_illegal;
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             taken_next;

    alu_ctl_decode u_decode (
        .opcode     (in_opcode),
        .funct3     (in_funct3),
        .funct7_5   (in_funct7_5),
        .alu_ctl    (dec_ctl),
        .a_sel      (dec_a_sel),
        .b_sel      (dec_b_sel),
        .shift_mask (dec_shift_mask),
        .is_branch  (dec_is_branch),
        .is_jump    (dec_is_jump),
        .illegal    (dec_illegal)
    );

    // Operand muxing; shift amounts keep only the low five bits.
    always_comb begin
        src_a_next = '0;
        src_b_raw  = '0;
        case (dec_a_sel)
            A_RS1:   src_a_next = in_rs1_val;
            A_PC:    src_a_next = in_pc;
            default: src_a_next = '0;
        endcase
        case (dec_b_sel)
            B_RS2:   src_b_raw = in_rs2_val;
            B_IMM:   src_b_raw = in_imm;
            B_FOUR:  src_b_raw = WIDTH'(4);
            default: src_b_raw = '0;
        endcase
        src_b_next = dec_shift_mask ? {{(WIDTH-5){1'b0}}, src_b_raw[4:0]} : src_b_raw;
    end

    // Handshake: writeback frees when empty or drained, issue moves into it.
    always_comb begin
        s2_adv     = !out_valid || out_ready;
        s1_adv     = s1_valid && s2_adv;
        in_ready   = !s1_valid || s2_adv;
        accept     = in_valid && in_ready && !flush;
        taken_next = !s1_illegal && (s1_is_jump || (s1_is_branch && alu_zero));
    end

    // Issue stage: payload loads only on accept so it holds through stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            alu_ctl      <= ALU_ADD;
            alu_src_a    <= '0;
            alu_src_b    <= '0;
            s1_is_branch <= 1'b0;
            s1_is_jump   <= 1'b0;
            s1_illegal   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid     <= 1'b1;
            alu_ctl      <= dec_ctl;
            alu_src_a    <= src_a_next;
            alu_src_b    <= src_b_next;
            s1_is_branch <= dec_is_branch;
            s1_is_jump   <= dec_is_jump;
            s1_illegal   <= dec_illegal;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Writeback stage: captures the ALU result as the issue entry advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_result       <= '0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s1_adv) begin
            out_valid        <= 1'b1;
            out_result       <= alu_result;
            out_branch_taken <= taken_next;
            out_illegal      <= s1_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
